// File: rtl/uart_rx_peripheral_if.sv
// Load-side handshake between the receive FIFO and the core.
// The peripheral owns the FIFO status and head byte; the core owns the pop strobe.
interface uart_rx_peripheral_if;
  logic       i_uart_rx_rden;
  logic [7:0] o_uart_rx_pdata;
  logic       o_uart_fifo_empty;
  logic       o_uart_fifo_full;

  modport master (
    output i_uart_rx_rden,
    input  o_uart_rx_pdata, o_uart_fifo_empty, o_uart_fifo_full
  );

  modport slave (
    input  i_uart_rx_rden,
    output o_uart_rx_pdata, o_uart_fifo_empty, o_uart_fifo_full
  );
endinterface

// File: rtl/uart_rx_peripheral.sv
// UART receiver: 2-flop synchronizer, start/data/parity/stop framing with a
// per-frame latched bit period, and a show-ahead receive FIFO popped by the core.
module uart_rx_peripheral #(
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic                 i_uart_clk,
  input  logic                 i_uart_rst_n,
  input  logic [19:0]          i_uart_baud_divisor,
  input  logic                 i_uart_parity_en,
  input  logic                 i_uart_parity_type,
  input  logic                 i_uart_rx_sdata,
  uart_rx_peripheral_if.slave  rx_if,
  output logic                 o_uart_rx_busy,
  output logic                 o_uart_parity_error,
  output logic                 o_uart_frame_error,
  output logic                 o_uart_overrun
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // synchronizer and edge history; idle line is high, so reset to 1
  logic sync1_q, rx_s_q, rx_prev_q;
  logic rx_fall;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] div_q, div_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_en_q, par_en_d;
  logic        par_type_q, par_type_d;
  logic        par_bad_q, par_bad_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        push, pop, fifo_full, fifo_empty;

  assign rx_fall = rx_prev_q & ~rx_s_q;

  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_uart_rx_sdata;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // frame FSM: counter runs D-1..0 per bit, first load is half a bit to hit mid-bit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bitn_d     = bitn_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          div_d      = i_uart_baud_divisor;
          par_en_d   = i_uart_parity_en;
          par_type_d = i_uart_parity_type;
          par_bad_d  = 1'b0;
          cnt_d      = (i_uart_baud_divisor >> 1) - 20'd1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 20'd0) begin
          if (rx_s_q) begin
            state_d = S_IDLE;             // glitch, not a real start bit
          end else begin
            cnt_d   = div_q - 20'd1;
            bitn_d  = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 20'd0) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};   // LSB first
          cnt_d   = div_q - 20'd1;
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q == 20'd0) begin
          par_bad_d = ((^shreg_q) ^ rx_s_q) != par_type_q;
          cnt_d     = div_q - 20'd1;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 20'd0) begin
          // leave mid-stop-bit so the next start edge is caught back-to-back
          state_d = S_IDLE;
          if (!rx_s_q)        ferr_d = 1'b1;
          else if (par_bad_q) perr_d = 1'b1;
          else if (fifo_full) ovr_d  = 1'b1;
          else                push   = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // frame state and registered error pulses
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bitn_q     <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bitn_q     <= bitn_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // FIFO pointers carry one extra wrap bit to tell full from empty
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = rx_if.i_uart_rx_rden & ~fifo_empty;

  // pointer advance; push is already gated by the pre-pop full flag
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  // FIFO pointer registers
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge i_uart_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  assign rx_if.o_uart_rx_pdata   = fifo_empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign rx_if.o_uart_fifo_empty = fifo_empty;
  assign rx_if.o_uart_fifo_full  = fifo_full;
  assign o_uart_rx_busy          = (state_q != S_IDLE);
  assign o_uart_parity_error     = perr_q;
  assign o_uart_frame_error      = ferr_q;
  assign o_uart_overrun          = ovr_q;
endmodule
